i2c_read_byte_vr: RTL

- I2C read master, the companion to the existing single-register I2C write master in the VCM/light-sensor control path.
- Performs a pointer-addressed read: START, {addr,W}, POINTER, repeated START, {addr,R}, then 1 or 2 data bytes, NACK, STOP.
- Bit-banged and advanced one phase per PT_CK edge. PT_CK is the slow I2C tick clock.
- Returns the read data and the slave-ACK status to the sequencing logic using the same GO/END_OK handshake as the write master.

---
 rtl/i2c_read_byte_vr.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_read_byte_vr.sv
// Pointer-addressed I2C read master: START, {addr,W}, POINTER, Sr, {addr,R}, 1..2 data bytes, NACK, STOP.
// Optional build macro I2C_RD_NACK_ABORT_EN: a slave NACK jumps straight to STOP and keeps the old RDATA.
module i2c_read_byte_vr #(
    parameter int NUM_BYTES = 1
) (
    input  logic        PT_CK,
    input  logic        RESET,
    input  logic        GO,
    input  logic [7:0]  POINTER,
    input  logic [7:0]  SLAVE_ADDRESS,
    input  logic        SDAI,
    output logic        SDAO,
    output logic        SCLO,
    output logic        END_OK,
    output logic [15:0] RDATA,
    output logic        ACK_OK,
    output logic [7:0]  ST
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        WAIT_GO_LOW = 4'd1,
        ARM         = 4'd2,
        START       = 4'd3,
        TX_BYTE     = 4'd4,
        RSTART      = 4'd5,
        RX_BYTE     = 4'd6,
        STOP        = 4'd7,
        DONE        = 4'd8
    } state_t;

    localparam logic [1:0] LAST_RX = (NUM_BYTES == 2) ? 2'd1 : 2'd0;

    state_t      state_r, state_s;
    logic [1:0]  phase_r, phase_s;
    logic [3:0]  bit_r, bit_s;
    logic [1:0]  byte_r, byte_s;
    logic [1:0]  tick_r, tick_s;
    logic [7:0]  shreg_r, shreg_s;
    logic [7:0]  byte0_r, byte0_s;
    logic        ack_acc_r, ack_acc_s;
    logic        aborted_r, aborted_s;
    logic        sdao_r, sdao_s;
    logic        sclo_r, sclo_s;
    logic        end_ok_r, end_ok_s;
    logic [15:0] rdata_r, rdata_s;
    logic        ack_ok_r, ack_ok_s;
    logic [7:0]  tx_s;
    logic        abort_s;
    logic        addr_unused_s;

    // The R/W bit is generated here, so the caller's bit 0 is don't-care.
    assign addr_unused_s = SLAVE_ADDRESS[0];

`ifdef I2C_RD_NACK_ABORT_EN
    assign abort_s = SDAI;
`else
    assign abort_s = 1'b0;
`endif

    function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic [7:0] addr,
                                           input logic [7:0] ptr);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {addr[7:1], 1'b0};
            2'd1:    b = ptr;
            2'd2:    b = {addr[7:1], 1'b1};
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    assign tx_s = tx_byte(byte_r, SLAVE_ADDRESS, POINTER);

    // Next-state and next-output decode; every tick is one bus phase.
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        bit_s     = bit_r;
        byte_s    = byte_r;
        tick_s    = tick_r;
        shreg_s   = shreg_r;
        byte0_s   = byte0_r;
        ack_acc_s = ack_acc_r;
        aborted_s = aborted_r;
        sdao_s    = sdao_r;
        sclo_s    = sclo_r;
        end_ok_s  = end_ok_r;
        rdata_s   = rdata_r;
        ack_ok_s  = ack_ok_r;
        case (state_r)
            IDLE: begin
                sdao_s   = 1'b1;
                sclo_s   = 1'b1;
                end_ok_s = 1'b1;
                if (GO) begin
                    state_s = WAIT_GO_LOW;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_GO_LOW: begin
                if (!GO) begin
                    state_s = ARM;
                end else begin
                    state_s = WAIT_GO_LOW;
                end
            end
            ARM: begin
                end_ok_s  = 1'b0;
                phase_s   = 2'd0;
                bit_s     = 4'd0;
                byte_s    = 2'd0;
                tick_s    = 2'd0;
                ack_acc_s = 1'b1;
                aborted_s = 1'b0;
                state_s   = START;
            end
            START: begin
                case (tick_r)
                    2'd0:    begin sdao_s = 1'b1; sclo_s = 1'b1; end
                    2'd1:    begin sdao_s = 1'b0; sclo_s = 1'b1; end
                    default: begin sdao_s = 1'b0; sclo_s = 1'b0; end
                endcase
                if (tick_r == 2'd2) begin
                    state_s = TX_BYTE;
                    tick_s  = 2'd0;
                    phase_s = 2'd0;
                    bit_s   = 4'd0;
                    byte_s  = 2'd0;
                end else begin
                    tick_s = tick_r + 2'd1;
                end
            end
            TX_BYTE: begin
                phase_s = phase_r + 2'd1;
                case (phase_r)
                    2'd0: sclo_s = 1'b0;
                    2'd1: begin
                        if (bit_r == 4'd8) begin
                            sdao_s = 1'b1;
                        end else begin
                            sdao_s = tx_s[3'd7 - bit_r[2:0]];
                        end
                    end
                    2'd2: sclo_s = 1'b1;
                    default: begin
                        if (bit_r == 4'd8) begin
                            ack_acc_s = ack_acc_r & ~SDAI;
                            bit_s     = 4'd0;
                            if (abort_s) begin
                                aborted_s = 1'b1;
                                tick_s    = 2'd0;
                                state_s   = STOP;
                            end else if (byte_r == 2'd0) begin
                                byte_s = 2'd1;
                            end else if (byte_r == 2'd1) begin
                                tick_s  = 2'd0;
                                state_s = RSTART;
                            end else begin
                                byte_s  = 2'd0;
                                state_s = RX_BYTE;
                            end
                        end else begin
                            bit_s = bit_r + 4'd1;
                        end
                    end
                endcase
            end
            RSTART: begin
                case (tick_r)
                    2'd0:    begin sdao_s = 1'b1; sclo_s = 1'b0; end
                    2'd1:    begin sdao_s = 1'b1; sclo_s = 1'b1; end
                    2'd2:    begin sdao_s = 1'b0; sclo_s = 1'b1; end
                    default: begin sdao_s = 1'b0; sclo_s = 1'b0; end
                endcase
                if (tick_r == 2'd3) begin
                    tick_s  = 2'd0;
                    phase_s = 2'd0;
                    bit_s   = 4'd0;
                    byte_s  = 2'd2;
                    state_s = TX_BYTE;
                end else begin
                    tick_s = tick_r + 2'd1;
                end
            end
            RX_BYTE: begin
                phase_s = phase_r + 2'd1;
                case (phase_r)
                    2'd0: sclo_s = 1'b0;
                    2'd1: begin
                        // Master ACKs every byte except the last, which gets a NACK.
                        if (bit_r == 4'd8) begin
                            sdao_s = (byte_r == LAST_RX) ? 1'b1 : 1'b0;
                        end else begin
                            sdao_s = 1'b1;
                        end
                    end
                    2'd2: sclo_s = 1'b1;
                    default: begin
                        if (bit_r == 4'd8) begin
                            bit_s = 4'd0;
                            if (byte_r == 2'd0) begin
                                byte0_s = shreg_r;
                            end else begin
                                byte0_s = byte0_r;
                            end
                            if (byte_r == LAST_RX) begin
                                tick_s  = 2'd0;
                                state_s = STOP;
                            end else begin
                                byte_s = byte_r + 2'd1;
                            end
                        end else begin
                            shreg_s = {shreg_r[6:0], SDAI};
                            bit_s   = bit_r + 4'd1;
                        end
                    end
                endcase
            end
            STOP: begin
                case (tick_r)
                    2'd0:    begin sdao_s = 1'b0; sclo_s = 1'b0; end
                    2'd1:    begin sdao_s = 1'b0; sclo_s = 1'b1; end
                    default: begin sdao_s = 1'b1; sclo_s = 1'b1; end
                endcase
                if (tick_r == 2'd2) begin
                    tick_s  = 2'd0;
                    state_s = DONE;
                end else begin
                    tick_s = tick_r + 2'd1;
                end
            end
            DONE: begin
                end_ok_s = 1'b1;
                ack_ok_s = ack_acc_r;
                if (aborted_r) begin
                    rdata_s = rdata_r;
                end else if (NUM_BYTES == 2) begin
                    rdata_s = {byte0_r, shreg_r};
                end else begin
                    rdata_s = {8'h00, shreg_r};
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered bus/handshake outputs.
    always_ff @(posedge PT_CK) begin
        if (RESET) begin
            state_r   <= IDLE;
            phase_r   <= 2'd0;
            bit_r     <= 4'd0;
            byte_r    <= 2'd0;
            tick_r    <= 2'd0;
            shreg_r   <= 8'h00;
            byte0_r   <= 8'h00;
            ack_acc_r <= 1'b0;
            aborted_r <= 1'b0;
            sdao_r    <= 1'b1;
            sclo_r    <= 1'b1;
            end_ok_r  <= 1'b1;
            rdata_r   <= 16'h0000;
            ack_ok_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            phase_r   <= phase_s;
            bit_r     <= bit_s;
            byte_r    <= byte_s;
            tick_r    <= tick_s;
            shreg_r   <= shreg_s;
            byte0_r   <= byte0_s;
            ack_acc_r <= ack_acc_s;
            aborted_r <= aborted_s;
            sdao_r    <= sdao_s;
            sclo_r    <= sclo_s;
            end_ok_r  <= end_ok_s;
            rdata_r   <= rdata_s;
            ack_ok_r  <= ack_ok_s;
        end
    end

    assign SDAO   = sdao_r;
    assign SCLO   = sclo_r;
    assign END_OK = end_ok_r;
    assign RDATA  = rdata_r;
    assign ACK_OK = ack_ok_r;
    assign ST     = {4'h0, state_r};

endmodule
